// File: rtl/list_ctrl_arb.sv
// Round-robin arbiter sharing a two-port list controller among NUM_REQ requesters.
// Define LIST_CTRL_ARB_HAZARD_EN to also block requests whose index matches an access in flight.
module list_ctrl_arb #(
    parameter int NUM_REQ     = 4,
    parameter int list_depth  = 4,
    parameter int index_lenth = 4,
    localparam int TW = (list_depth > 1) ? $clog2(list_depth) : 1,
    localparam int IW = index_lenth,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*IW-1:0] req_index,
    input  logic [NUM_REQ*2-1:0]  req_cmd,
    input  logic [NUM_REQ*3-1:0]  req_status,
    input  logic [NUM_REQ*TW-1:0] req_tag,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [NUM_REQ*TW-1:0] rsp_tag,
    output logic                  acc_req_0,
    output logic [IW-1:0]         acc_index_0,
    output logic [1:0]            acc_cmd_0,
    output logic [2:0]            acc_status_0,
    output logic [TW-1:0]         acc_tag_0,
    output logic                  acc_req_1,
    output logic [IW-1:0]         acc_index_1,
    output logic [1:0]            acc_cmd_1,
    output logic [2:0]            acc_status_1,
    output logic [TW-1:0]         acc_tag_1,
    input  logic [TW-1:0]         return_tag_0,
    input  logic [TW-1:0]         return_tag_1
);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               pick0_vld, pick1_vld;
    logic [PW-1:0]      pick0, pick1;

    logic [IW-1:0] idx_arr [NUM_REQ];
    logic [1:0]    cmd_arr [NUM_REQ];
    logic [2:0]    st_arr  [NUM_REQ];
    logic [TW-1:0] tag_arr [NUM_REQ];

    // Owner pipelines: stage 1 lines up with acc_req_x, stage 2 with the returned tag.
    logic [PW-1:0] own0_s1, own1_s1, own0_s2, own1_s2;
    logic          own0_s2_vld, own1_s2_vld;

    function automatic logic [PW-1:0] rr_pos(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return PW'(sum % NUM_REQ);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_arr[i] = req_index[i*IW +: IW];
            cmd_arr[i] = req_cmd[i*2 +: 2];
            st_arr[i]  = req_status[i*3 +: 3];
            tag_arr[i] = req_tag[i*TW +: TW];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i];
`ifdef LIST_CTRL_ARB_HAZARD_EN
            if (acc_req_0 && idx_arr[i] == acc_index_0) eligible[i] = 1'b0;
            if (acc_req_1 && idx_arr[i] == acc_index_1) eligible[i] = 1'b0;
`endif
        end
    end

    // Walk requesters in priority order; the second pick must target a different index.
    always_comb begin
        pick0_vld = 1'b0;
        pick1_vld = 1'b0;
        pick0     = '0;
        pick1     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (eligible[rr_pos(rr_ptr, k)]) begin
                if (!pick0_vld) begin
                    pick0_vld = 1'b1;
                    pick0     = rr_pos(rr_ptr, k);
                end else if (!pick1_vld && idx_arr[rr_pos(rr_ptr, k)] != idx_arr[pick0]) begin
                    pick1_vld = 1'b1;
                    pick1     = rr_pos(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            if (pick0_vld) req_ready[pick0] = 1'b1;
            if (pick1_vld) req_ready[pick1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            acc_req_0    <= 1'b0;
            acc_index_0  <= '0;
            acc_cmd_0    <= '0;
            acc_status_0 <= '0;
            acc_tag_0    <= '0;
            acc_req_1    <= 1'b0;
            acc_index_1  <= '0;
            acc_cmd_1    <= '0;
            acc_status_1 <= '0;
            acc_tag_1    <= '0;
            own0_s1      <= '0;
            own1_s1      <= '0;
        end else begin
            acc_req_0    <= pick0_vld;
            acc_index_0  <= pick0_vld ? idx_arr[pick0] : '0;
            acc_cmd_0    <= pick0_vld ? cmd_arr[pick0] : '0;
            acc_status_0 <= pick0_vld ? st_arr[pick0]  : '0;
            acc_tag_0    <= pick0_vld ? tag_arr[pick0] : '0;
            acc_req_1    <= pick1_vld;
            acc_index_1  <= pick1_vld ? idx_arr[pick1] : '0;
            acc_cmd_1    <= pick1_vld ? cmd_arr[pick1] : '0;
            acc_status_1 <= pick1_vld ? st_arr[pick1]  : '0;
            acc_tag_1    <= pick1_vld ? tag_arr[pick1] : '0;
            own0_s1      <= pick0;
            own1_s1      <= pick1;
            if (pick1_vld)      rr_ptr <= rr_pos(pick1, 1);
            else if (pick0_vld) rr_ptr <= rr_pos(pick0, 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own0_s2_vld <= 1'b0;
            own1_s2_vld <= 1'b0;
            own0_s2     <= '0;
            own1_s2     <= '0;
            rsp_valid   <= '0;
            rsp_tag     <= '0;
        end else begin
            own0_s2_vld <= acc_req_0;
            own1_s2_vld <= acc_req_1;
            own0_s2     <= own0_s1;
            own1_s2     <= own1_s1;
            rsp_valid   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (own0_s2_vld && own0_s2 == PW'(i)) begin
                    rsp_valid[i]         <= 1'b1;
                    rsp_tag[i*TW +: TW]  <= return_tag_0;
                end
                if (own1_s2_vld && own1_s2 == PW'(i)) begin
                    rsp_valid[i]         <= 1'b1;
                    rsp_tag[i*TW +: TW]  <= return_tag_1;
                end
            end
        end
    end

endmodule

// File: tb/tb_list_ctrl_arb.sv
// Scoreboard bench for list_ctrl_arb: a queue-based reference model predicts grants, accesses
// and responses; a negedge monitor pops and compares them against the DUT.
module tb_list_ctrl_arb;

    localparam int NUM_REQ = 4;
    localparam int TW      = 2;
    localparam int IW      = 4;
    localparam int CW      = NUM_REQ * 2;
    localparam int SW      = NUM_REQ * 3;
    localparam int GW      = NUM_REQ * TW;
    localparam int MAXC    = 4096;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
    logic [NUM_REQ*IW-1:0] req_index;
    logic [CW-1:0]         req_cmd;
    logic [SW-1:0]         req_status;
    logic [GW-1:0]         req_tag, rsp_tag;
    logic                  acc_req_0, acc_req_1;
    logic [IW-1:0]         acc_index_0, acc_index_1;
    logic [1:0]            acc_cmd_0, acc_cmd_1;
    logic [2:0]            acc_status_0, acc_status_1;
    logic [TW-1:0]         acc_tag_0, acc_tag_1, return_tag_0, return_tag_1;

    always #5 clk = ~clk;

    list_ctrl_arb #(.NUM_REQ(NUM_REQ), .list_depth(4), .index_lenth(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_cmd(req_cmd), .req_status(req_status), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .acc_req_0(acc_req_0), .acc_index_0(acc_index_0), .acc_cmd_0(acc_cmd_0),
        .acc_status_0(acc_status_0), .acc_tag_0(acc_tag_0),
        .acc_req_1(acc_req_1), .acc_index_1(acc_index_1), .acc_cmd_1(acc_cmd_1),
        .acc_status_1(acc_status_1), .acc_tag_1(acc_tag_1),
        .return_tag_0(return_tag_0), .return_tag_1(return_tag_1)
    );

    typedef struct {int cyc; logic [IW-1:0] idx; logic [1:0] cmd; logic [2:0] st; logic [TW-1:0] tag;} acc_t;
    typedef struct {int cyc; int id; logic [TW-1:0] tag;} rsp_t;
    typedef struct {int cyc; logic [NUM_REQ-1:0] rdy;} rdy_t;

    acc_t acc0_q[$];
    acc_t acc1_q[$];
    rsp_t rsp_q[$];
    rdy_t rdy_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int forced_tag = -1;

    int            m_rr = 0;
    bit            m_acc_vld [2];
    logic [IW-1:0] m_acc_idx [2];
    logic [TW-1:0] ret_sched [2][MAXC];
    bit            ret_set   [2][MAXC];

    logic [NUM_REQ-1:0]    rnd_v;
    logic [NUM_REQ*IW-1:0] rnd_ix;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_grant(input int port, input int id, input logic [NUM_REQ*IW-1:0] ix);
        acc_t a;
        rsp_t r;
        a.cyc = cyc + 1;
        a.idx = ix[id*IW +: IW];
        a.cmd = req_cmd[id*2 +: 2];
        a.st  = req_status[id*3 +: 3];
        a.tag = req_tag[id*TW +: TW];
        if (port == 0) acc0_q.push_back(a);
        else           acc1_q.push_back(a);
        r.cyc = cyc + 3;
        r.id  = id;
        r.tag = (forced_tag >= 0) ? TW'(forced_tag) : TW'($urandom);
        ret_sched[port][cyc+2] = r.tag;
        ret_set[port][cyc+2]   = 1'b1;
        rsp_q.push_back(r);
    endtask

    // Drive one cycle of stimulus and record what the DUT must do in response.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*IW-1:0] ix,
                                  input bit do_reset);
        int   order[$];
        int   p0, p1, last;
        rdy_t e;
        @(posedge clk);
        #1;
        rst_n        = !do_reset;
        req_valid    = v;
        req_index    = ix;
        req_cmd      = CW'($urandom);
        req_status   = SW'($urandom);
        req_tag      = GW'($urandom);
        return_tag_0 = ret_set[0][cyc] ? ret_sched[0][cyc] : TW'($urandom);
        return_tag_1 = ret_set[1][cyc] ? ret_sched[1][cyc] : TW'($urandom);
        e.cyc = cyc;
        e.rdy = '0;
        if (do_reset) begin
            m_rr = 0;
            m_acc_vld[0] = 1'b0;
            m_acc_vld[1] = 1'b0;
            acc0_q.delete();
            acc1_q.delete();
            rsp_q.delete();
            rdy_q.push_back(e);
            return;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            int r  = (m_rr + k) % NUM_REQ;
            bit ok = v[r];
`ifdef LIST_CTRL_ARB_HAZARD_EN
            for (int x = 0; x < 2; x++)
                if (m_acc_vld[x] && m_acc_idx[x] == ix[r*IW +: IW]) ok = 1'b0;
`endif
            if (ok) order.push_back(r);
        end
        p0 = (order.size() > 0) ? order[0] : -1;
        p1 = -1;
        for (int j = 1; j < order.size(); j++)
            if (p1 < 0 && ix[order[j]*IW +: IW] != ix[p0*IW +: IW]) p1 = order[j];
        m_acc_vld[0] = (p0 >= 0);
        m_acc_vld[1] = (p1 >= 0);
        if (p0 >= 0) begin
            e.rdy[p0]    = 1'b1;
            m_acc_idx[0] = ix[p0*IW +: IW];
            push_grant(0, p0, ix);
        end
        if (p1 >= 0) begin
            e.rdy[p1]    = 1'b1;
            m_acc_idx[1] = ix[p1*IW +: IW];
            push_grant(1, p1, ix);
        end
        rdy_q.push_back(e);
        last = (p1 >= 0) ? p1 : p0;
        if (last >= 0) m_rr = (last + 1) % NUM_REQ;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            acc_t               ea0, ea1;
            bit                 f0, f1;
            rdy_t               er;
            rsp_t               rr;
            logic [NUM_REQ-1:0] ev;
            logic [GW-1:0]      et;
            if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
                er = rdy_q.pop_front();
                check_output("req_ready", 32'(req_ready), 32'(er.rdy));
            end
            f0 = 1'b0; ea0.idx = '0; ea0.cmd = '0; ea0.st = '0; ea0.tag = '0;
            f1 = 1'b0; ea1.idx = '0; ea1.cmd = '0; ea1.st = '0; ea1.tag = '0;
            if (acc0_q.size() > 0 && acc0_q[0].cyc == cyc) begin ea0 = acc0_q.pop_front(); f0 = 1'b1; end
            if (acc1_q.size() > 0 && acc1_q[0].cyc == cyc) begin ea1 = acc1_q.pop_front(); f1 = 1'b1; end
            check_output("acc_req_0",    32'(acc_req_0),    32'(f0));
            check_output("acc_index_0",  32'(acc_index_0),  32'(ea0.idx));
            check_output("acc_cmd_0",    32'(acc_cmd_0),    32'(ea0.cmd));
            check_output("acc_status_0", 32'(acc_status_0), 32'(ea0.st));
            check_output("acc_tag_0",    32'(acc_tag_0),    32'(ea0.tag));
            check_output("acc_req_1",    32'(acc_req_1),    32'(f1));
            check_output("acc_index_1",  32'(acc_index_1),  32'(ea1.idx));
            check_output("acc_cmd_1",    32'(acc_cmd_1),    32'(ea1.cmd));
            check_output("acc_status_1", 32'(acc_status_1), 32'(ea1.st));
            check_output("acc_tag_1",    32'(acc_tag_1),    32'(ea1.tag));
            ev = '0;
            et = '0;
            while (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                rr = rsp_q.pop_front();
                ev[rr.id]          = 1'b1;
                et[rr.id*TW +: TW] = rr.tag;
            end
            check_output("rsp_valid", 32'(rsp_valid), 32'(ev));
            for (int i = 0; i < NUM_REQ; i++)
                if (ev[i]) check_output("rsp_tag", 32'(rsp_tag[i*TW +: TW]), 32'(et[i*TW +: TW]));
            if (!rst_n) check_output("rsp_tag_in_reset", 32'(rsp_tag), 32'd0);
        end
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_index    = '0;
        req_cmd      = '0;
        req_status   = '0;
        req_tag      = '0;
        return_tag_0 = '0;
        return_tag_1 = '0;
        mon_en       = 1'b1;
        $display("[TB] start");
        repeat (2) apply_stimulus('0, '0, 1'b1);

        // All four requesters with distinct indices rotate in pairs.
        repeat (3) apply_stimulus(4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
        // Same index on requesters 0 and 1 serialises them.
        apply_stimulus(4'b0011, {4'd0, 4'd0, 4'd5, 4'd5}, 1'b0);
        repeat (2) apply_stimulus(4'b0010, {4'd0, 4'd0, 4'd5, 4'd5}, 1'b0);
        // In-flight index collision on requester 3.
        apply_stimulus(4'b0100, {4'd0, 4'd3, 4'd0, 4'd0}, 1'b0);
        repeat (2) apply_stimulus(4'b1000, {4'd3, 4'd0, 4'd0, 4'd0}, 1'b0);
        // Reset between a handshake and its response.
        apply_stimulus(4'b0011, {4'd0, 4'd0, 4'd7, 4'd6}, 1'b0);
        apply_stimulus('0, '0, 1'b1);
        repeat (4) apply_stimulus('0, '0, 1'b0);
        // Requester 1 on port 1 gets return tag 2 back.
        forced_tag = 2;
        apply_stimulus(4'b0011, {4'd0, 4'd0, 4'd9, 4'd8}, 1'b0);
        forced_tag = -1;
        repeat (3) apply_stimulus('0, '0, 1'b0);
        // Lone requester 3 with a fresh index every cycle.
        for (int k = 0; k < 6; k++) apply_stimulus(4'b1000, {IW'(k), 12'd0}, 1'b0);

        for (int n = 0; n < 600; n++) begin
            rnd_v = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) rnd_ix[i*IW +: IW] = IW'($urandom_range(0, 3));
            apply_stimulus(rnd_v, rnd_ix, ($urandom_range(0, 49) == 0));
        end
        repeat (5) apply_stimulus('0, '0, 1'b0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check_output("drain", 32'(acc0_q.size() + acc1_q.size() + rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
